mem_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch requester (IF) and the load/store requester (LS) of the rv32i core. Fixed priority LS > IF, with a starvation override for IF. One outstanding memory transaction at a time, using a req/gnt handshake upstream and a req/ready/rvalid handshake downstream. Sits between pc/instruction-fetch plus load/store control and the shared memory model.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arb_priority.sv | 46 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter of the rv32i core:
// data width, access-size encoding, arbiter FSM states and owner tags.
package mem_arbiter_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_LS = 1'b1
  } arb_owner_t;

  // Starvation counter width; a zero limit still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection for the memory arbiter: LS has priority over IF unless
// IF has been denied STARVE_LIMIT consecutive cycles. Holds the starvation
// counter and produces the combinational grants (only while idle).
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic ls_req,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             if_win;

  // A zero limit disables the override entirely.
  assign starved = (STARVE_LIMIT > 0) && (starve_cnt == LIMIT_C);
  assign if_win  = if_req && (!ls_req || starved);

  // Grants are masked during reset so every output reads 0 while rst is high.
  assign if_gnt = idle && !rst && if_win;
  assign ls_gnt = idle && !rst && ls_req && !if_win;

  // Count consecutive denied IF-request cycles, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (STARVE_LIMIT > 0) begin
      if (!if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and load/store (LS). One transaction in flight: IDLE -> REQ -> RESP.
// Optional build macro MEM_ARB_PERF_EN adds perf_conflict_cnt, counting
// IDLE cycles in which both requesters asked for the memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  mem_size_t             ls_size,
  input  logic                  ls_sign,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output mem_size_t             mem_size,
  output logic                  mem_sign,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_REQ  = ARB_REQ;
  localparam logic [1:0] ST_RESP = ARB_RESP;

  logic [1:0]            state;
  arb_owner_t            owner;
  logic                  idle;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign idle     = (state == ST_IDLE);
  assign mem_req  = (state == ST_REQ);
  assign rsp_done = (state == ST_RESP) && mem_rvalid;
  // Writes complete with a zero data word regardless of the bus contents.
  assign rsp_data = mem_we ? '0 : mem_rdata;

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_priority (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_gnt (if_gnt),
    .ls_gnt (ls_gnt)
  );

  // FSM and transaction latch: fields captured at grant, held through REQ/RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= ARB_OWN_IF;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= MEM_WORD;
      mem_sign  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_gnt) begin
            owner     <= ARB_OWN_IF;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_size  <= MEM_WORD;
            mem_sign  <= 1'b0;
            state     <= ST_REQ;
          end else if (ls_gnt) begin
            owner     <= ARB_OWN_LS;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_size  <= ls_size;
            mem_sign  <= ls_sign;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ready) state <= ST_RESP;
        end
        ST_RESP: begin
          if (mem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Route the completion to the owner only; rdata holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (rsp_done) begin
        if (owner == ARB_OWN_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= rsp_data;
        end else begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= rsp_data;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Count idle cycles where both requesters contend (wraps at 2^32).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
    end else if (idle && if_req && ls_req) begin
      perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a word-array memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int DW    = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_sign;
  logic [DW-1:0] ls_addr, ls_wdata;
  mem_size_t     ls_size;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we, mem_sign;
  logic [DW-1:0] mem_addr, mem_wdata;
  mem_size_t     mem_size;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_conflict_cnt;
`endif

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_size(ls_size), .ls_sign(ls_sign), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  logic [31:0] mem_arr[256];
  logic [31:0] ref_arr[256];

  // Reference model state
  bit          busy, pend, mphase;
  int          wait_cnt, delay;
  logic [31:0] resp_data;
  bit          e_we, e_sign;
  logic [31:0] e_addr, e_wdata;
  mem_size_t   e_size;
  logic [31:0] perf_exp;
  int          ready_pct, if_pct, ls_pct;

  // Values applied after the next rising edge
  logic          n_if_req, n_ls_req, n_ls_we, n_ls_sign, n_ready, n_rvalid;
  logic [DW-1:0] n_if_addr, n_ls_addr, n_ls_wdata, n_rdata;
  mem_size_t     n_ls_size;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0111);
  endfunction

  task automatic cycle(input bit allow_new);
    bit       exp_if, exp_ls;
    bit [7:0] idx;
    @(negedge clk);
    exp_if = !busy && if_req && (!ls_req || (LIMIT > 0 && wait_cnt == LIMIT));
    exp_ls = !busy && ls_req && !exp_if;
    chk("if_gnt", if_gnt, exp_if);
    chk("ls_gnt", ls_gnt, exp_ls);
    chk("mem_req", mem_req, pend);
    if (pend) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_size", 32'(mem_size), 32'(e_size));
      chk("mem_sign", mem_sign, e_sign);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_conflict_cnt", perf_conflict_cnt, perf_exp);
`endif
    if (!busy && if_req && ls_req) perf_exp++;

    // memory side of this edge
    if (mphase) begin
      if (mem_rvalid) begin
        mphase = 0;
        busy   = 0;
      end
    end else if (pend && mem_ready) begin
      idx = mem_addr[9:2];
      if (mem_we) begin
        mem_arr[idx] = mem_wdata;
        resp_data    = $urandom;
      end else begin
        resp_data = mem_arr[idx];
      end
      pend   = 0;
      mphase = 1;
      delay  = $urandom_range(0, 2);
    end

    // grant of this edge
    if (exp_if) begin
      busy = 1; pend = 1;
      e_we = 0; e_addr = if_addr; e_wdata = '0; e_size = MEM_WORD; e_sign = 0;
      sb.push_back('{is_if: 1'b1, data: ref_arr[if_addr[9:2]]});
    end else if (exp_ls) begin
      busy = 1; pend = 1;
      e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata; e_size = ls_size; e_sign = ls_sign;
      if (ls_we) begin
        ref_arr[ls_addr[9:2]] = ls_wdata;
        sb.push_back('{is_if: 1'b0, data: 32'h0});
      end else begin
        sb.push_back('{is_if: 1'b0, data: ref_arr[ls_addr[9:2]]});
      end
    end

    if (LIMIT > 0) begin
      if (if_req && !exp_if) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
      else wait_cnt = 0;
    end

    // memory drive for the next cycle
    if (mphase) begin
      n_ready = 0;
      if (delay == 0) begin
        n_rvalid = 1;
        n_rdata  = resp_data;
      end else begin
        delay--;
        n_rvalid = 0;
        n_rdata  = $urandom;
      end
    end else begin
      n_ready  = ($urandom_range(0, 99) < ready_pct);
      n_rvalid = ($urandom_range(0, 4) == 0);
      n_rdata  = $urandom;
    end

    // requesters: new request after grant or when idle, rare early drop
    n_if_req = if_req; n_if_addr = if_addr;
    if (exp_if || !if_req || $urandom_range(0, 15) == 0) begin
      n_if_req  = allow_new && ($urandom_range(0, 99) < if_pct);
      n_if_addr = {22'd0, 8'($urandom), 2'b00};
    end
    n_ls_req = ls_req; n_ls_we = ls_we; n_ls_addr = ls_addr;
    n_ls_wdata = ls_wdata; n_ls_size = ls_size; n_ls_sign = ls_sign;
    if (exp_ls || !ls_req || $urandom_range(0, 15) == 0) begin
      n_ls_req   = allow_new && ($urandom_range(0, 99) < ls_pct);
      n_ls_we    = $urandom_range(0, 1);
      n_ls_addr  = $urandom & 32'h3FF;
      n_ls_wdata = $urandom;
      n_ls_size  = mem_size_t'($urandom_range(0, 2));
      n_ls_sign  = $urandom_range(0, 1);
    end

    @(posedge clk);
    #1;
    if_req = n_if_req; if_addr = n_if_addr;
    ls_req = n_ls_req; ls_we = n_ls_we; ls_addr = n_ls_addr;
    ls_wdata = n_ls_wdata; ls_size = n_ls_size; ls_sign = n_ls_sign;
    mem_ready = n_ready; mem_rvalid = n_rvalid; mem_rdata = n_rdata;
  endtask

  // Monitor: compares every completion pulse against the scoreboard
  initial begin
    logic [31:0] last_if, last_ls;
    rsp_t r;
    last_if = '0;
    last_ls = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_if = '0;
        last_ls = '0;
      end else begin
        chk("dual_rvalid", 32'(if_rvalid & ls_rvalid), 32'h0);
        if (if_rvalid || ls_rvalid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rvalid", {30'd0, ls_rvalid, if_rvalid}, 32'h0);
          end else begin
            r = sb.pop_front();
            chk("rvalid_owner_if", 32'(if_rvalid), 32'(r.is_if));
            chk("rdata", if_rvalid ? if_rdata : ls_rdata, r.data);
          end
        end else begin
          chk("if_rdata_hold", if_rdata, last_if);
          chk("ls_rdata_hold", ls_rdata, last_ls);
        end
        last_if = if_rdata;
        last_ls = ls_rdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1;
    if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_size = MEM_WORD; ls_sign = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    busy = 0; pend = 0; mphase = 0; wait_cnt = 0; delay = 0; perf_exp = '0;
    resp_data = '0; e_we = 0; e_sign = 0; e_addr = '0; e_wdata = '0; e_size = MEM_WORD;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = init_word(i);
      ref_arr[i] = init_word(i);
    end

    repeat (2) @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_ls_rvalid", ls_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_size", 32'(mem_size), 32'(MEM_WORD));
    chk("rst_mem_sign", mem_sign, 0);
`ifdef MEM_ARB_PERF_EN
    chk("rst_perf", perf_conflict_cnt, 0);
`endif
    @(posedge clk);
    #1 rst = 0;

    ready_pct = 60; if_pct = 50; ls_pct = 50;
    repeat (1200) cycle(1);
    ready_pct = 12;
    repeat (600) cycle(1);
    ready_pct = 85; if_pct = 95; ls_pct = 97;
    repeat (1200) cycle(1);

    n = 0;
    while ((busy || sb.size() != 0 || if_req || ls_req) && n < 200) begin
      cycle(0);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    mem_ready = 0; mem_rvalid = 0;

    // reset in REQ of an LS write
    ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678;
    ls_size = MEM_WORD; ls_sign = 0;
    @(negedge clk);
    chk("rstx_ls_gnt", ls_gnt, 1);
    @(posedge clk);
    #1 ls_req = 0;
    @(negedge clk);
    chk("rstx_mem_req_before", mem_req, 1);
    chk("rstx_mem_addr_before", mem_addr, 32'h40);
    #1 ls_req = 1; rst = 1;
    #1;
    chk("rstx_mem_req", mem_req, 0);
    chk("rstx_mem_we", mem_we, 0);
    chk("rstx_mem_addr", mem_addr, 0);
    chk("rstx_mem_wdata", mem_wdata, 0);
    chk("rstx_mem_size", 32'(mem_size), 32'(MEM_WORD));
    chk("rstx_ls_gnt", ls_gnt, 0);
    chk("rstx_if_gnt", if_gnt, 0);
    ls_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 mem_rvalid = 0; mem_ready = 0;
    repeat (6) begin
      @(negedge clk);
      chk("rstx_no_ls_rvalid", ls_rvalid, 0);
      chk("rstx_idle_mem_req", mem_req, 0);
    end
`ifdef MEM_ARB_PERF_EN
    chk("rstx_perf", perf_conflict_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
